stroke_rasterizer: RTL and testbench
====================================

// Module: stroke_rasterizer
//
// PURPOSE
//   Turns the sparse cursor points decoded from the MCU SPI link into a dense pixel-write
//   stream for the frame pixel store. Sits between the SPI receiver and the pixel store.
//   Consecutive pen-down points are joined by a Bresenham line, so fast strokes stay
//   continuous. Each point's 3-bit colour code is attached to every pixel of its segment.
//
// PARAMETERS
//   CW   8   coordinate width in bits (x and y, unsigned, 0..2**CW-1)
//   CCW  3   colour-code width; codes match the colour decoder's table
//
// PORTS
//   clk       in   1    pixel-domain clock
//   reset     in   1    synchronous, active-high
//   pt_valid  in   1    input point valid
//   pt_ready  out  1    rasterizer can accept a point
//   pt_x      in   CW   point x
//   pt_y      in   CW   point y
//   pt_pen    in   1    1 = draw from previous point; 0 = start new stroke (single pixel)
//   pt_color  in   CCW  colour code for this segment
//   px_valid  out  1    output pixel valid
//   px_ready  in   1    pixel store accepts pixel
//   px_x      out  CW   pixel x
//   px_y      out  CW   pixel y
//   px_color  out  CCW  pixel colour code
//   busy      out  1    high in any state except IDLE
//
// BEHAVIOUR
//   - Reset values:
//     - px_valid=0, busy=0, pt_ready=1, px_x/px_y/px_color=0.
//     - has_last=0, last_x/last_y=0, state=IDLE.
//   - Handshakes:
//     - A transfer happens on any cycle where valid&&ready. Both sides use valid/ready.
//     - px_x/px_y/px_color and px_valid hold stable while px_valid && !px_ready.
//     - pt_ready=1 only in IDLE; it is a registered state decode, with no path from px_ready.
//   - FSM states and transitions:
//     - IDLE  -> SETUP on point accept. Latch end=(pt_x,pt_y) and the colour.
//       Start point = (last_x,last_y) if pt_pen && has_last; otherwise start = end.
//     - SETUP: x0/y0 = start, x1/y1 = end.
//       - dx = |x1-x0|, dy = -|y1-y0|, err = dx+dy. Widths are signed CW+2; no wrap.
//       - sx, sy = +1 or -1, by direction.
//       - Load cur = start. Assert px_valid. Go to STEP.
//     - STEP, on each px handshake:
//       - If cur == end: drop px_valid, set last = end, has_last=1, go to IDLE.
//       - Else: e2 = 2*err.
//         - if e2 >= dy: cur_x += sx, err += dy.
//         - if e2 <= dx: cur_y += sy, err += dx.
//         - Both updates use the pre-step err and apply in the same cycle.
//   - Latency and throughput:
//     - Point accepted in cycle N; first px_valid in cycle N+2.
//     - With px_ready held high: 1 pixel/cycle, max(dx,|dy|)+1 pixels per segment.
//     - Both endpoints are emitted. The start pixel repeats the previous segment's end
//       pixel; this is harmless to the store.
//   - Boundaries:
//     - First point after reset is a single pixel regardless of pt_pen.
//     - Zero-length segment (end == last): exactly one pixel.
//     - Full-span lines (e.g. 0 <-> 2**CW-1) must not wrap.
//     - Colour change mid-stroke applies from the next segment only.
//     - Reset mid-segment: abort immediately. px_valid=0 next cycle, has_last=0.
//       No further pixels from the aborted segment.
//
// STRUCTURE
//   - drawing_pkg holds:
//     - coord_t (logic [CW-1:0]) and color_t (logic [CCW-1:0]).
//     - Colour-code localparams shared with the colour decoder, e.g. GREEN.
//     - rast_state_t enum {IDLE, SETUP, STEP}.
//   - Sub-module bresenham_core:
//     - Owns cur/err/dx/dy/sx/sy.
//     - Inputs load/step; outputs cur_x, cur_y, at_end.
//     - The FSM and handshake logic stay in stroke_rasterizer.
//
// TESTING
//   1. Reset, then pt (10,20) pen=0 colour 3 -> pt_ready=1 after reset; one pixel (10,20,c3);
//      px_valid at +2 cycles; busy back to 0.
//   2. (0,0) pen=0, then (3,0) pen=1 -> second segment gives (0,0),(1,0),(2,0),(3,0) on 4
//      consecutive cycles.
//   3. (5,5) pen=0, then (6,9) pen=1 -> (5,5),(5,6),(6,7),(6,8),(6,9).
//   4. (255,255) pen=0, then (0,0) pen=1 -> 256 pixels (255-k,255-k), no wrap;
//      last pixel (0,0).
//   5. Backpressure: drop px_ready for 3 cycles mid-segment of test 2 -> outputs frozen;
//      sequence unchanged; no pixel lost or duplicated; pt_ready stays 0.
//   6. Reset during test 4 at pixel 100 -> px_valid=0 next cycle; then (7,7) pen=1 -> single
//      pixel (7,7) (has_last cleared).

Source files
------------

// File: rtl/drawing_pkg.sv
// Shared drawing types: coordinate/colour types, colour codes, rasterizer states.
package drawing_pkg;

    localparam int CW  = 8;
    localparam int CCW = 3;

    typedef logic [CW-1:0]  coord_t;
    typedef logic [CCW-1:0] color_t;

    // Colour codes, identical to the colour decoder's lookup table
    localparam color_t BLACK   = 3'd0;
    localparam color_t RED     = 3'd1;
    localparam color_t GREEN   = 3'd2;
    localparam color_t BLUE    = 3'd3;
    localparam color_t YELLOW  = 3'd4;
    localparam color_t CYAN    = 3'd5;
    localparam color_t MAGENTA = 3'd6;
    localparam color_t WHITE   = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        STEP  = 2'd2
    } rast_state_t;

endpackage

// File: rtl/bresenham_core.sv
// Bresenham line walker: loads a segment, then advances one pixel per step.
// Arithmetic is CW+2 signed so full-span segments never wrap.
module bresenham_core #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic          i_step,
    input  logic [CW-1:0] i_x0,
    input  logic [CW-1:0] i_y0,
    input  logic [CW-1:0] i_x1,
    input  logic [CW-1:0] i_y1,
    output logic [CW-1:0] o_cur_x,
    output logic [CW-1:0] o_cur_y,
    output logic          o_at_end
);
    localparam int SW = CW + 2;

    logic signed [SW-1:0] r_dx, r_dy, r_err;
    logic                 r_sx_neg, r_sy_neg;
    logic [CW-1:0]        r_cur_x, r_cur_y, r_end_x, r_end_y;

    logic signed [SW-1:0] w_x0, w_y0, w_x1, w_y1, w_adx, w_ady, w_err_nxt;
    logic signed [SW:0]   w_e2;
    logic                 w_mv_x, w_mv_y;

    // Segment setup terms and the per-step decision, both from the pre-step error
    always_comb begin
        w_x0      = $signed({2'b00, i_x0});
        w_y0      = $signed({2'b00, i_y0});
        w_x1      = $signed({2'b00, i_x1});
        w_y1      = $signed({2'b00, i_y1});
        w_adx     = (w_x1 >= w_x0) ? (w_x1 - w_x0) : (w_x0 - w_x1);
        w_ady     = (w_y1 >= w_y0) ? (w_y1 - w_y0) : (w_y0 - w_y1);
        w_e2      = $signed({r_err, 1'b0});
        w_mv_x    = (w_e2 >= $signed({r_dy[SW-1], r_dy}));
        w_mv_y    = (w_e2 <= $signed({r_dx[SW-1], r_dx}));
        w_err_nxt = r_err + (w_mv_x ? r_dy : SW'(0)) + (w_mv_y ? r_dx : SW'(0));
    end

    // Walker state: load takes priority, step advances x and/or y in one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_cur_x  <= '0;
            r_cur_y  <= '0;
            r_end_x  <= '0;
            r_end_y  <= '0;
        end else if (i_load) begin
            r_cur_x  <= i_x0;
            r_cur_y  <= i_y0;
            r_end_x  <= i_x1;
            r_end_y  <= i_y1;
            r_dx     <= w_adx;
            r_dy     <= -w_ady;
            r_err    <= w_adx - w_ady;
            r_sx_neg <= (i_x1 < i_x0);
            r_sy_neg <= (i_y1 < i_y0);
        end else if (i_step) begin
            if (w_mv_x) r_cur_x <= r_sx_neg ? (r_cur_x - CW'(1)) : (r_cur_x + CW'(1));
            if (w_mv_y) r_cur_y <= r_sy_neg ? (r_cur_y - CW'(1)) : (r_cur_y + CW'(1));
            r_err <= w_err_nxt;
        end
    end

    assign o_cur_x  = r_cur_x;
    assign o_cur_y  = r_cur_y;
    assign o_at_end = (r_cur_x == r_end_x) && (r_cur_y == r_end_y);

endmodule

// File: rtl/stroke_rasterizer.sv
// Stroke rasterizer: joins consecutive pen-down points with Bresenham lines and
// streams the pixels, tagged with the segment colour, to the pixel store.
module stroke_rasterizer
    import drawing_pkg::*;
#(
    parameter int CW  = 8,
    parameter int CCW = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pt_valid,
    output logic           pt_ready,
    input  logic [CW-1:0]  pt_x,
    input  logic [CW-1:0]  pt_y,
    input  logic           pt_pen,
    input  logic [CCW-1:0] pt_color,
    output logic           px_valid,
    input  logic           px_ready,
    output logic [CW-1:0]  px_x,
    output logic [CW-1:0]  px_y,
    output logic [CCW-1:0] px_color,
    output logic           busy
);
    rast_state_t r_state, w_next;

    logic [CW-1:0]  r_end_x, r_end_y, r_start_x, r_start_y, r_last_x, r_last_y;
    logic [CCW-1:0] r_color;
    logic           r_has_last;

    logic w_accept, w_load, w_step, w_done, w_at_end;

    assign w_accept = (r_state == IDLE) && pt_valid;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state plus walker load/step strobes; stepping only on a pixel handshake
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE:  if (pt_valid) w_next = SETUP;
            SETUP: begin
                w_load = 1'b1;
                w_next = STEP;
            end
            STEP:  if (px_ready) begin
                if (w_at_end) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end else begin
                    w_step = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Point latch and stroke memory; a pen-up point or no history draws a single pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            r_end_x    <= '0;
            r_end_y    <= '0;
            r_start_x  <= '0;
            r_start_y  <= '0;
            r_color    <= '0;
            r_last_x   <= '0;
            r_last_y   <= '0;
            r_has_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_end_x <= pt_x;
                r_end_y <= pt_y;
                r_color <= pt_color;
                if (pt_pen && r_has_last) begin
                    r_start_x <= r_last_x;
                    r_start_y <= r_last_y;
                end else begin
                    r_start_x <= pt_x;
                    r_start_y <= pt_y;
                end
            end
            if (w_done) begin
                r_last_x   <= r_end_x;
                r_last_y   <= r_end_y;
                r_has_last <= 1'b1;
            end
        end
    end

    bresenham_core #(.CW(CW)) u_core (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_x0     (r_start_x),
        .i_y0     (r_start_y),
        .i_x1     (r_end_x),
        .i_y1     (r_end_y),
        .o_cur_x  (px_x),
        .o_cur_y  (px_y),
        .o_at_end (w_at_end)
    );

    // All handshake outputs decode the registered state, so pt_ready never sees px_ready
    assign pt_ready = (r_state == IDLE);
    assign px_valid = (r_state == STEP);
    assign busy     = (r_state != IDLE);
    assign px_color = r_color;

endmodule

// File: tb/tb_stroke_rasterizer.sv
// Scoreboard bench for stroke_rasterizer: a reference line model queues expected
// pixels per point; the monitor pops and compares on every pixel handshake.
module tb_stroke_rasterizer;
    localparam int CW  = 8;
    localparam int CCW = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           pt_valid, pt_ready, pt_pen;
    logic [CW-1:0]  pt_x, pt_y;
    logic [CCW-1:0] pt_color;
    logic           px_valid, px_ready, busy;
    logic [CW-1:0]  px_x, px_y;
    logic [CCW-1:0] px_color;

    int n_chk = 0;
    int n_err = 0;
    int n_px  = 0;
    int cyc   = 0;

    logic [18:0] sb[$];
    int          hs_cyc[$];

    int m_lx = 0, m_ly = 0;
    bit m_has = 1'b0;

    stroke_rasterizer #(.CW(CW), .CCW(CCW)) dut (
        .clk      (clk),
        .reset    (reset),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .pt_x     (pt_x),
        .pt_y     (pt_y),
        .pt_pen   (pt_pen),
        .pt_color (pt_color),
        .px_valid (px_valid),
        .px_ready (px_ready),
        .px_x     (px_x),
        .px_y     (px_y),
        .px_color (px_color),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference Bresenham: pushes {x,y,colour} for every pixel of the segment
    task automatic model_seg(input int x0, input int y0, input int x1, input int y1, input int c);
        int dx, dy, sx, sy, err, e2, x, y;
        logic [18:0] e;
        dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy  = (y1 > y0) ? -(y1 - y0) : -(y0 - y1);
        sx  = (x0 < x1) ? 1 : -1;
        sy  = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        x   = x0;
        y   = y0;
        forever begin
            e = {x[7:0], y[7:0], c[2:0]};
            sb.push_back(e);
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    // Queue expectations, then present the point until accepted; returns at accept-edge + 1
    task automatic send_pt(input int x, input int y, input bit pen, input int c);
        int n;
        if (pen && m_has) model_seg(m_lx, m_ly, x, y, c);
        else              model_seg(x, y, x, y, c);
        m_lx = x; m_ly = y; m_has = 1'b1;
        pt_valid = 1'b1;
        pt_x     = CW'(x);
        pt_y     = CW'(y);
        pt_pen   = pen;
        pt_color = CCW'(c);
        n = 0;
        while (!pt_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) chk("pt_accept_timeout", n, 0);
        @(posedge clk); #1;
        pt_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) chk("idle_timeout", n, 0);
    endtask

    task automatic wait_px(input int target);
        int n;
        n = 0;
        while (n_px < target && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) chk("px_timeout", n_px, target);
    endtask

    // Monitor: one scoreboard pop per pixel handshake
    always @(negedge clk) begin
        if (!reset && px_valid && px_ready) begin
            n_px++;
            hs_cyc.push_back(cyc);
            if (sb.size() == 0) chk("px_unexpected", 32'({px_x, px_y, px_color}), -1);
            else                chk("px", 32'({px_x, px_y, px_color}), 32'(sb.pop_front()));
        end
    end

    initial begin
        int base, sz;
        logic [CW-1:0] fx, fy;
        reset = 1'b1; pt_valid = 1'b0; pt_x = '0; pt_y = '0; pt_pen = 1'b0;
        pt_color = '0; px_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pt_ready", 32'(pt_ready), 1);
        chk("rst_px_valid", 32'(px_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_px_xyc", 32'({px_x, px_y, px_color}), 0);
        reset = 1'b0;

        // 1: single pixel, latency N+2
        send_pt(10, 20, 1'b0, 3);
        chk("t1_n1_px_valid", 32'(px_valid), 0);
        chk("t1_n1_busy", 32'(busy), 1);
        chk("t1_n1_pt_ready", 32'(pt_ready), 0);
        @(posedge clk); #1;
        chk("t1_n2_px_valid", 32'(px_valid), 1);
        wait_idle();
        chk("t1_busy_done", 32'(busy), 0);

        // 2: horizontal run, one pixel per cycle
        send_pt(0, 0, 1'b0, 1);
        wait_idle();
        send_pt(3, 0, 1'b1, 2);
        wait_idle();
        sz = hs_cyc.size();
        for (int k = 1; k <= 3; k++) chk("t2_contig", hs_cyc[sz-4+k] - hs_cyc[sz-5+k], 1);

        // 3: steep segment, then a colour change on the next segment
        send_pt(5, 5, 1'b0, 4);
        wait_idle();
        send_pt(6, 9, 1'b1, 4);
        wait_idle();
        send_pt(8, 9, 1'b1, 6);
        wait_idle();

        // 4: full-span diagonal, no wrap
        send_pt(255, 255, 1'b0, 7);
        wait_idle();
        base = n_px;
        send_pt(0, 0, 1'b1, 7);
        wait_idle();
        chk("t4_count", n_px - base, 256);

        // 5: backpressure mid-segment
        send_pt(0, 0, 1'b0, 1);
        wait_idle();
        base = n_px;
        send_pt(3, 0, 1'b1, 1);
        wait_px(base + 2);
        px_ready = 1'b0;
        fx = px_x; fy = px_y;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("t5_hold_valid", 32'(px_valid), 1);
            chk("t5_hold_xy", 32'({px_x, px_y}), 32'({fx, fy}));
            chk("t5_pt_ready", 32'(pt_ready), 0);
        end
        px_ready = 1'b1;
        wait_idle();
        chk("t5_count", n_px - base, 4);

        // 6: reset mid-segment, then a pen-down point must draw alone
        send_pt(255, 255, 1'b0, 2);
        wait_idle();
        base = n_px;
        send_pt(0, 0, 1'b1, 2);
        wait_px(base + 100);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        m_has = 1'b0;
        chk("t6_px_valid", 32'(px_valid), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_pt_ready", 32'(pt_ready), 1);
        repeat (5) @(posedge clk);
        #1;
        base = n_px;
        chk("t6_no_stray_px", n_px - base, 0);
        send_pt(7, 7, 1'b1, 5);
        wait_idle();
        chk("t6_single_px", n_px - base, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
